// File: rtl/sum_inc_pkg.sv
// Shared types and carry-select helper for the sum/increment adder output stage.
package sum_inc_pkg;

  localparam int unsigned SUM_W_DEFAULT = 16;
  localparam int unsigned SUM_W_MAX     = 64;

  typedef struct packed {
    logic [SUM_W_DEFAULT-1:0] h;
    logic [SUM_W_DEFAULT-1:0] g;
    logic [SUM_W_DEFAULT-1:0] x;
    logic                     inc;
  } pfx_word_t;

  // Carry into bit i selects between G[i-1:0] (A+B) and G|X (A+B+1); bit WIDTH is cout.
  function automatic logic [SUM_W_MAX:0] sel_carry(input logic [SUM_W_MAX-1:0] g,
                                                   input logic [SUM_W_MAX-1:0] x,
                                                   input logic                 inc);
    logic [SUM_W_MAX:0] c;
    c[0] = inc;
    for (int unsigned i = 1; i <= SUM_W_MAX; i++) begin
      c[i] = g[i-1] | (inc & x[i-1]);
    end
    return c;
  endfunction

endpackage

// File: rtl/sum_select_stage_pipe_slice.sv
// One valid/ready register slice with a parameterised payload width.
module pipe_slice #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/sum_select_stage.sv
// Kogge-Stone sum/increment output stage: two-slice pipeline, S1 holds prefix word, S2 holds result.
// Optional signed-overflow output enabled by defining SUM_SEL_OVF_EN.
module sum_select_stage
  import sum_inc_pkg::*;
#(
  parameter int unsigned WIDTH = SUM_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_h,
  input  logic [WIDTH-1:0] in_g,
  input  logic [WIDTH-1:0] in_x,
  input  logic             in_inc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  // Same field layout as pfx_word_t, sized by this instance's WIDTH.
  typedef struct packed {
    logic [WIDTH-1:0] h;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] x;
    logic             inc;
  } s1_word_t;

  localparam int unsigned S1_W = 3 * WIDTH + 1;
`ifdef SUM_SEL_OVF_EN
  localparam int unsigned S2_W = WIDTH + 2;
`else
  localparam int unsigned S2_W = WIDTH + 1;
`endif

  s1_word_t           s1_in;
  s1_word_t           s1_q;
  logic               s1_valid;
  logic               s2_ready;
  logic [SUM_W_MAX:0] carry_full;
  logic [WIDTH:0]     c;
  logic [WIDTH-1:0]   sum;
  logic [S2_W-1:0]    s2_d;
  logic [S2_W-1:0]    s2_q;
  logic               unused_carry;

  assign s1_in = '{h: in_h, g: in_g, x: in_x, inc: in_inc};

  pipe_slice #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_q)
  );

  assign carry_full   = sel_carry(SUM_W_MAX'(s1_q.g), SUM_W_MAX'(s1_q.x), s1_q.inc);
  assign c            = carry_full[WIDTH:0];
  assign unused_carry = ^carry_full[SUM_W_MAX:WIDTH+1];
  assign sum          = s1_q.h ^ c[WIDTH-1:0];

`ifdef SUM_SEL_OVF_EN
  assign s2_d = {sum, c[WIDTH], c[WIDTH-1] ^ c[WIDTH]};
  assign {out_sum, out_cout, out_ovf} = s2_q;
`else
  assign s2_d = {sum, c[WIDTH]};
  assign {out_sum, out_cout} = s2_q;
  assign out_ovf = 1'b0;
`endif

  pipe_slice #(.W(S2_W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_q)
  );

endmodule

// File: tb/tb_sum_select_stage.sv
// Scoreboard bench for sum_select_stage (WIDTH=16); honours SUM_SEL_OVF_EN for the overflow output.
module tb_sum_select_stage;
  import sum_inc_pkg::*;

`ifdef SUM_SEL_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_h = '0;
  logic [15:0] in_g = '0;
  logic [15:0] in_x = '0;
  logic        in_inc = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          id;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        inc;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   next_id = 0;

  vec_t tbl[10] = '{
    '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0},
    '{16'h00FF, 16'h0001, 1'b1, 16'h0101, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0},
    '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1},
    '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0},
    '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0},
    '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1},
    '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0},
    '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0},
    '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0}
  };

  sum_select_stage #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_h      (in_h),
    .in_g      (in_g),
    .in_x      (in_x),
    .in_inc    (in_inc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Behavioural prefix tree: G[i:0] is the carry out of a[i:0]+b[i:0], X[i:0] = &h[i:0].
  function automatic pfx_word_t pfx(input logic [15:0] a, input logic [15:0] b, input logic inc);
    pfx_word_t   w;
    logic [16:0] mask;
    logic [16:0] s;
    w.h   = a ^ b;
    w.inc = inc;
    for (int i = 0; i < 16; i++) begin
      mask   = (17'h1 << (i + 1)) - 17'h1;
      s      = ({1'b0, a} & mask) + ({1'b0, b} & mask);
      w.g[i] = s[i+1];
      w.x[i] = (i == 0) ? w.h[0] : (w.x[i-1] & w.h[i]);
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic send(input vec_t v, output int blocked);
    pfx_word_t w;
    w = pfx(v.a, v.b, v.inc);
    @(negedge clk);
    in_h = w.h; in_g = w.g; in_x = w.x; in_inc = w.inc; in_valid = 1'b1;
    #1;
    blocked = 0;
    while (!in_ready && blocked < 100) begin
      @(negedge clk);
      #1;
      blocked++;
    end
    if (!in_ready) begin
      check("send_timeout", 32'(in_ready), 32'd1);
    end else begin
      q.push_back('{v.s, v.c, OVF_EN ? v.o : 1'b0, next_id});
      next_id++;
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(name, 32'(q.size()), 32'd0);
  endtask

  // Monitor: pops on every output transfer, checks hold-stability while stalled.
  initial begin
    exp_t        e;
    logic [17:0] prev = '0;
    bit          have_prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        q.delete();
        have_prev = 1'b0;
      end else if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got sum=0x%0h cout=%0b, required no output", out_sum, out_cout);
        end else begin
          e = q.pop_front();
          check($sformatf("result_%0d", e.id), {14'd0, out_sum, out_cout, out_ovf},
                {14'd0, e.sum, e.cout, e.ovf});
        end
        have_prev = 1'b0;
      end else if (out_valid) begin
        if (have_prev) check("stall_hold", {14'd0, out_sum, out_cout, out_ovf}, {14'd0, prev});
        prev      = {out_sum, out_cout, out_ovf};
        have_prev = 1'b1;
      end else begin
        have_prev = 1'b0;
      end
    end
  end

  initial begin
    int   blk;
    vec_t bp[3];
    vec_t rv[3];
    bp[0] = '{16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0};
    bp[1] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    bp[2] = '{16'h8001, 16'h7FFF, 1'b1, 16'h0001, 1'b1, 1'b0};
    rv[0] = '{16'h0005, 16'h0005, 1'b0, 16'h000A, 1'b0, 1'b0};
    rv[1] = '{16'h0100, 16'h0200, 1'b1, 16'h0301, 1'b0, 1'b0};
    rv[2] = '{16'h0002, 16'h0003, 1'b1, 16'h0006, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_sum",   32'(out_sum),   32'd0);
    check("reset_out_cout",  32'(out_cout),  32'd0);
    check("reset_out_ovf",   32'(out_ovf),   32'd0);
    check("reset_in_ready",  32'(in_ready),  32'd1);

    // Latency: result visible on the second negedge after the accepting edge.
    send(tbl[0], blk);
    idle();
    #1;
    check("latency_cycle1_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    check("latency_cycle2_out_valid", 32'(out_valid), 32'd1);
    drain("drain_latency");

    for (int i = 1; i < 10; i++) send(tbl[i], blk);
    idle();
    drain("drain_stream");

    // Backpressure: two words fill the stages, the third waits for out_ready.
    @(negedge clk);
    out_ready = 1'b0;
    send(bp[0], blk);
    send(bp[1], blk);
    fork
      begin
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
    join_none
    send(bp[2], blk);
    check("backpressure_blocked_cycles", 32'(blk), 32'd4);
    idle();
    drain("drain_backpressure");

    // Reset with both stages full: flushed words must never appear.
    @(negedge clk);
    out_ready = 1'b0;
    send(rv[0], blk);
    send(rv[1], blk);
    @(negedge clk);
    #1;
    check("full_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_out_sum",   32'(out_sum),   32'd0);
    check("flush_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    send(rv[2], blk);
    idle();
    drain("drain_post_reset");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
